// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the execute-stage shifter
package cpu_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRA = 2'b01,
        SH_ROR = 2'b10,
        SH_SRL = 2'b11
    } shift_mode_t;

    localparam int DATA_W = 16;

    // Pipeline stage that owns a given shift level.
    function automatic int stage_of(input int level, input int stages, input int levels);
        return (level * stages) / levels;
    endfunction

endpackage

// File: rtl/shifter_pipe_if.sv
// rtl/shifter_pipe_if.sv - operand/result handshake bundle for shifter_pipe
interface shifter_pipe_if #(
    parameter int WIDTH = cpu_pkg::DATA_W
) ();
    import cpu_pkg::*;

    localparam int SW = $clog2(WIDTH);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] shift_in;
    logic [SW-1:0]    shift_val;
    shift_mode_t      mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] shift_out;
    logic             zero;

    modport master (
        output flush, in_valid, shift_in, shift_val, mode, out_ready,
        input  in_ready, out_valid, shift_out, zero
    );

    modport slave (
        input  flush, in_valid, shift_in, shift_val, mode, out_ready,
        output in_ready, out_valid, shift_out, zero
    );

endinterface

// File: rtl/shift_level.sv
// rtl/shift_level.sv - one combinational barrel level shifting by a fixed AMOUNT
module shift_level import cpu_pkg::*; #(
    parameter int WIDTH  = DATA_W,
    parameter int AMOUNT = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  shift_mode_t      mode,
    output logic [WIDTH-1:0] result
);

    // Earlier SRA levels keep the sign bit, so data's MSB is the original sign.
    always_comb begin
        result = data;
        if (en) begin
            case (mode)
                SH_SLL: result = {data[WIDTH-1-AMOUNT:0], {AMOUNT{1'b0}}};
                SH_SRA: result = {{AMOUNT{data[WIDTH-1]}}, data[WIDTH-1:AMOUNT]};
                SH_ROR: result = {data[AMOUNT-1:0], data[WIDTH-1:AMOUNT]};
                SH_SRL: result = {{AMOUNT{1'b0}}, data[WIDTH-1:AMOUNT]};
                default: result = data;
            endcase
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined barrel shifter with valid/ready, flush and zero flag
module shifter_pipe import cpu_pkg::*; #(
    parameter int WIDTH  = DATA_W,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    shifter_pipe_if.slave   bus
);

    localparam int L = $clog2(WIDTH);

    logic [WIDTH-1:0] lvl_in    [L];
    logic [WIDTH-1:0] lvl_out   [L];
    logic             lvl_en    [L];
    shift_mode_t      lvl_mode  [L];

    logic [WIDTH-1:0] stage_res [STAGES];
    logic [WIDTH-1:0] st_data   [STAGES];
    logic [L-1:0]     st_sv     [STAGES];
    shift_mode_t      st_mode   [STAGES];
    logic             st_valid  [STAGES];
    logic [STAGES-1:0] adv;
    logic             zero_q;
    logic             unused_ctrl;

    // A stage moves if any stage at or after it is empty, or the consumer takes the result.
    always_comb begin
        logic hole;
        hole = 1'b0;
        adv  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            hole   = hole | ~st_valid[k];
            adv[k] = hole | bus.out_ready;
        end
    end

    assign bus.in_ready  = adv[0] & ~bus.flush;
    assign bus.out_valid = st_valid[STAGES-1];
    assign bus.shift_out = st_data[STAGES-1];
    assign bus.zero      = zero_q;

    for (genvar i = 0; i < L; i++) begin : g_lvl
        localparam int  ST    = stage_of(i, STAGES, L);
        localparam bit  FIRST = (i == 0) || (stage_of(i - 1, STAGES, L) != ST);
        localparam bit  LAST  = (i == L - 1) || (stage_of(i + 1, STAGES, L) != ST);

        if (FIRST && ST == 0) begin : g_src_in
            assign lvl_in[i] = bus.shift_in;
        end else if (FIRST) begin : g_src_reg
            assign lvl_in[i] = st_data[ST-1];
        end else begin : g_src_chain
            assign lvl_in[i] = lvl_out[i-1];
        end

        if (ST == 0) begin : g_ctl_in
            assign lvl_en[i]   = bus.shift_val[i];
            assign lvl_mode[i] = bus.mode;
        end else begin : g_ctl_reg
            assign lvl_en[i]   = st_sv[ST-1][i];
            assign lvl_mode[i] = st_mode[ST-1];
        end

        shift_level #(
            .WIDTH  (WIDTH),
            .AMOUNT (1 << i)
        ) u_level (
            .data   (lvl_in[i]),
            .en     (lvl_en[i]),
            .mode   (lvl_mode[i]),
            .result (lvl_out[i])
        );

        if (LAST) begin : g_tap
            assign stage_res[ST] = lvl_out[i];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic         in_v;
        logic [L-1:0] in_sv;
        shift_mode_t  in_mode;

        if (s == 0) begin : g_head
            assign in_v    = bus.in_valid;
            assign in_sv   = bus.shift_val;
            assign in_mode = bus.mode;
        end else begin : g_body
            assign in_v    = st_valid[s-1];
            assign in_sv   = st_sv[s-1];
            assign in_mode = st_mode[s-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_valid[s] <= 1'b0;
                st_data[s]  <= '0;
                st_sv[s]    <= '0;
                st_mode[s]  <= SH_SLL;
            end else if (bus.flush) begin
                st_valid[s] <= 1'b0;
            end else if (adv[s]) begin
                st_valid[s] <= in_v;
                if (in_v) begin
                    st_data[s] <= stage_res[s];
                    st_sv[s]   <= in_sv;
                    st_mode[s] <= in_mode;
                end
            end
        end

        // Zero flag travels with the final-stage result register.
        if (s == STAGES - 1) begin : g_zero
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    zero_q <= 1'b0;
                end else if (bus.flush) begin
                    zero_q <= 1'b0;
                end else if (adv[s]) begin
                    zero_q <= in_v & (stage_res[s] == '0);
                end
            end
        end
    end

    // Last-stage control and low shift_val bits are carried but never consumed.
    always_comb begin
        unused_ctrl = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            unused_ctrl = unused_ctrl ^ (^st_sv[k]) ^ (^st_mode[k]);
        end
    end

endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - randomized and directed bench for shifter_pipe across four configurations
module tb_shifter_pipe;
    import cpu_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        zero;
        int          acc;
        bit          lat;
    } item_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] shift_in;
    logic [4:0]  shift_val;
    shift_mode_t mode;
    logic        lat_mode;
    logic        done;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;

    logic        o16_valid;
    logic        o16_ready;
    logic        o16_zero;
    logic [15:0] o16_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cfg_w(input int c);
        return (c == 0) ? 16 : 32;
    endfunction

    function automatic int cfg_s(input int c);
        case (c)
            0: return 2;
            1: return 1;
            2: return 3;
            default: return 5;
        endcase
    endfunction

    function automatic logic [31:0] model_shift(input int w, input shift_mode_t m,
                                                input logic [31:0] din, input int amt);
        logic [63:0] mask, d, r;
        mask = (64'd1 << w) - 64'd1;
        d    = {32'd0, din} & mask;
        case (m)
            SH_SLL: r = (d << amt) & mask;
            SH_SRL: r = d >> amt;
            SH_SRA: begin
                r = d >> amt;
                if (d[w-1]) r = r | (mask & ~(mask >> amt));
            end
            default: r = ((d >> amt) | (d << (w - amt))) & mask;
        endcase
        return r[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    for (genvar c = 0; c < 4; c++) begin : g_cfg
        localparam int W  = cfg_w(c);
        localparam int S  = cfg_s(c);
        localparam int SW = $clog2(W);

        shifter_pipe_if #(.WIDTH(W)) bus ();

        assign bus.flush     = flush;
        assign bus.in_valid  = in_valid;
        assign bus.out_ready = out_ready;
        assign bus.shift_in  = shift_in[W-1:0];
        assign bus.shift_val = shift_val[SW-1:0];
        assign bus.mode      = mode;

        shifter_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        if (c == 0) begin : g_tap
            assign o16_valid = bus.out_valid;
            assign o16_ready = bus.in_ready;
            assign o16_zero  = bus.zero;
            assign o16_data  = bus.shift_out[15:0];
        end

        item_t q[$];

        always @(posedge clk) begin : p_model
            item_t it;
            if (!rst_n) begin
                q.delete();
            end else begin
                if (bus.out_valid && out_ready && q.size() > 0) begin
                    if (q[0].lat)
                        check($sformatf("latency_w%0d_s%0d", W, S), cyc - q[0].acc, S);
                    void'(q.pop_front());
                end
                if (flush) begin
                    q.delete();
                end else if (in_valid && bus.in_ready) begin
                    it.data = model_shift(W, mode, shift_in, int'(shift_val[SW-1:0]));
                    it.zero = (it.data == 32'd0);
                    it.acc  = cyc;
                    it.lat  = lat_mode;
                    q.push_back(it);
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                check($sformatf("in_ready_w%0d_s%0d", W, S), bus.in_ready,
                      !flush && (out_ready || q.size() < S));
                if (bus.out_valid) begin
                    if (q.size() == 0) begin
                        check($sformatf("spurious_w%0d_s%0d", W, S), bus.out_valid, 0);
                    end else begin
                        check($sformatf("data_w%0d_s%0d", W, S), bus.shift_out, q[0].data);
                        check($sformatf("zero_w%0d_s%0d", W, S), bus.zero, q[0].zero);
                    end
                end
            end
        end

        always @(posedge done)
            check($sformatf("drain_w%0d_s%0d", W, S), q.size(), 0);
    end

    task automatic run_op(input shift_mode_t m, input logic [15:0] din, input int amt,
                          input logic [15:0] exp, input logic expz, input string nm);
        mode      = m;
        shift_in  = {16'h0000, din};
        shift_val = 5'(amt);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check({nm, "_ready"}, o16_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({nm, "_early"}, o16_valid, 0);
        @(posedge clk); #1;
        check({nm, "_valid"}, o16_valid, 1);
        check({nm, "_data"}, o16_data, exp);
        check({nm, "_zero"}, o16_zero, expz);
    endtask

    initial begin : p_main
        shift_mode_t bp_mode [4];
        logic [15:0] bp_din  [4];
        int          bp_amt  [4];
        logic [15:0] bp_exp  [4];
        logic [15:0] hold;
        int p, stall, npop;
        bit seen, saw_drop, held;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        shift_in = '0; shift_val = '0; mode = SH_SLL; lat_mode = 1'b0; done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", o16_valid, 0);
        check("rst_shift_out", o16_data, 0);
        check("rst_zero", o16_zero, 0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("rst_in_ready", o16_ready, 1);
        @(posedge clk); #1;

        run_op(SH_SLL, 16'h3BCA, 10, 16'h2800, 1'b0, "sll_3bca_10");
        run_op(SH_SRA, 16'h3BCA, 10, 16'h000E, 1'b0, "sra_3bca_10");
        run_op(SH_SRA, 16'h8000, 15, 16'hFFFF, 1'b0, "sra_8000_15");
        run_op(SH_SRL, 16'h8000, 15, 16'h0001, 1'b0, "srl_8000_15");
        run_op(SH_ROR, 16'h3BCA, 4,  16'hA3BC, 1'b0, "ror_3bca_4");
        run_op(SH_SLL, 16'h8000, 1,  16'h0000, 1'b1, "sll_8000_1");
        for (int m = 0; m < 4; m++)
            run_op(shift_mode_t'(m), 16'hA5C3, 0, 16'hA5C3, 1'b0, $sformatf("by0_mode%0d", m));
        repeat (6) @(posedge clk);
        #1;

        // Back-to-back stream with a three-cycle consumer stall.
        bp_mode = '{SH_SLL, SH_SRL, SH_ROR, SH_SRA};
        bp_din  = '{16'h0001, 16'h8000, 16'h00F0, 16'hF000};
        bp_amt  = '{1, 3, 4, 4};
        bp_exp  = '{16'h0002, 16'h1000, 16'h000F, 16'hFF00};
        p = 0; stall = 0; npop = 0; seen = 0; saw_drop = 0; held = 0; hold = '0;
        for (int c = 0; c < 14; c++) begin
            in_valid = (p < 4);
            if (p < 4) begin
                mode = bp_mode[p]; shift_in = {16'h0, bp_din[p]}; shift_val = 5'(bp_amt[p]);
            end
            if (!seen && o16_valid) begin seen = 1; stall = 3; end
            out_ready = (stall == 0);
            #1;
            if (!o16_ready) saw_drop = 1;
            if (o16_valid && !out_ready) begin
                if (!held) begin hold = o16_data; held = 1; end
                else check("bp_stable", o16_data, hold);
            end
            if (o16_valid && out_ready && npop < 4) begin
                check($sformatf("bp_order%0d", npop), o16_data, bp_exp[npop]);
                npop++;
            end
            if (in_valid && o16_ready) p++;
            @(posedge clk); #1;
            if (stall > 0) stall--;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_ready_drop", saw_drop, 1);
        check("bp_count", npop, 4);
        repeat (6) @(posedge clk);
        #1;

        // Flush with two ops in flight and a third presented in the flush cycle.
        mode = SH_SLL; shift_in = 32'h0003; shift_val = 5'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        mode = SH_SRL; shift_in = 32'hFF00; shift_val = 5'd8;
        @(posedge clk); #1;
        mode = SH_ROR; shift_in = 32'h0001; shift_val = 5'd1; flush = 1'b1;
        #1 check("flush_in_ready", o16_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("flush_quiet%0d", i), o16_valid, 0);
            @(posedge clk); #1;
        end
        run_op(SH_SRA, 16'h8F00, 4, 16'hF8F0, 1'b0, "post_flush");
        repeat (6) @(posedge clk);
        #1;

        // Asynchronous reset while a result sits stalled at the output.
        mode = SH_SRL; shift_in = 32'h00F0; shift_val = 5'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("prerst_valid", o16_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", o16_valid, 0);
        check("async_rst_data", o16_data, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("post_rst_ready", o16_ready, 1);
        @(posedge clk); #1;
        run_op(SH_ROR, 16'h1234, 8, 16'h3412, 1'b0, "post_rst_op");

        // Random traffic, no stalls: exact latency is checked for every op.
        lat_mode = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            shift_in  = $urandom;
            if ($urandom_range(0, 7) == 0) shift_in = 32'h1 << $urandom_range(0, 31);
            shift_val = 5'($urandom);
            mode      = shift_mode_t'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 lat_mode = 1'b0;

        // Random traffic with backpressure and occasional flushes.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            shift_in  = $urandom;
            if ($urandom_range(0, 7) == 0) shift_in = 32'h1 << $urandom_range(0, 31);
            shift_val = 5'($urandom);
            mode      = shift_mode_t'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1 done = 1'b1;
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Parametrised, pipelined barrel shifter for the CPU execute stage. It is the successor to the single-cycle combinational 16-bit shifter.
- Adds a WIDTH parameter, configurable pipeline depth, and four modes: SLL, SRA, ROR and SRL.
- Adds valid/ready handshaking with backpressure, a flush input and a zero flag.
- Sits between the operand-forwarding muxes and the EX/MEM result select.

Parameters:
- WIDTH, 16, data width; power of two, minimum 4.
- STAGES, 2, number of pipeline register stages; range 1 to $clog2(WIDTH).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush
- in_valid  input  1  input operation valid
- in_ready  output  1  shifter can accept an operation this cycle
- shift_in  input  WIDTH  operand
- shift_val  input  $clog2(WIDTH)  shift amount
- mode  input  2  00 SLL, 01 SRA, 10 ROR, 11 SRL
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- shift_out  output  WIDTH  result
- zero  output  1  shift_out == 0, qualified by out_valid

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all stage valids 0, shift_out 0, zero 0, out_valid 0. in_ready is 1 once reset is released.
- Shift levels: L = $clog2(WIDTH) levels; level i shifts by 2^i when shift_val[i] is set.
  - Level i is placed in stage floor(i*STAGES/L).
  - Each stage register holds: partial data, full shift_val, mode, valid.
- Mode semantics:
  - SLL fills with 0.
  - SRA fills with shift_in[WIDTH-1].
  - ROR rotates right by shift_val.
  - SRL fills with 0.
  - shift_val = 0 passes shift_in unchanged in every mode.
  - Shift amounts stay below WIDTH by construction, so there is no overflow case.
- Latency: an operation accepted in cycle N gives out_valid in cycle N+STAGES when no stall occurs.
- Throughput: one operation per cycle.
- Handshakes:
  - Input transfer happens when in_valid && in_ready.
  - Output transfer happens when out_valid && out_ready.
- Advance rule:
  - Stage k advances when it is empty or stage k+1 advances.
  - The last stage advances when it is empty or out_ready is high.
  - in_ready = stage 0 advances.
  - This is a bubble-collapsing pipeline: an empty stage accepts even when downstream is stalled.
- Stall: a stalled stage holds its data and valid. shift_out, zero and out_valid stay stable while out_valid && !out_ready.
- zero is computed on the final-stage result and registered with it. It is only meaningful while out_valid is high.
- Flush:
  - All stage valids clear on the next edge.
  - An in_valid presented in the flush cycle is dropped.
  - in_ready is held 0 during flush.
  - Data registers are don't-care after flush.
- Flush and out_ready high in the same cycle: the output is consumed and no new valid appears.
- Reset mid-operation: all in-flight operations are lost immediately, asynchronously. No output is produced for them.
- mode is sampled with the operand and carried down the pipe. A later mode change does not affect in-flight operations.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef enum logic [1:0] shift_mode_t {SH_SLL, SH_SRA, SH_ROR, SH_SRL}
  - constant DATA_W = 16
- One sub-module, shift_level. It is a combinational single level, parametrised by WIDTH and AMOUNT (= 2^i), with inputs data, en and mode.
- shifter_pipe instantiates L shift_level blocks via generate and inserts registers at the stage boundaries.

Test Plan (WIDTH=16, STAGES=2):
- SLL 0x3BCA by 10, out_ready=1 -> shift_out=0x2800 two cycles after acceptance, zero=0.
- Arithmetic and fill checks:
  - SRA 0x3BCA by 10 -> 0x000E.
  - SRA 0x8000 by 15 -> 0xFFFF.
  - SRL 0x8000 by 15 -> 0x0001.
  - ROR 0x3BCA by 4 -> 0xA3BC.
  - SLL 0x8000 by 1 -> 0x0000 with zero=1.
  - Any mode by 0 -> unchanged.
- Back-to-back with backpressure:
  - Stimulus: stream 4 ops on consecutive cycles, with out_ready held 0 for the 3 cycles starting when the first result appears.
  - Required: in_ready drops once both stages are full, shift_out stays stable while stalled, all 4 results emerge in order with none lost or duplicated.
- Flush while 2 ops are in flight, plus in_valid in the same cycle -> out_valid stays 0 for the next 3 cycles; a following op completes normally with 2-cycle latency.
- Assert rst_n low asynchronously mid-cycle while an op is in flight -> out_valid=0, shift_out=0 immediately. After release, in_ready=1 and the first new op completes correctly.
- Parameter sweep:
  - Configurations: WIDTH=32 with STAGES=1, 3 and 5.
  - Stimulus: random mode/shift_in/shift_val against a behavioural model.
  - Required: latency equals STAGES in every configuration, and results match the model bit-exactly.
